ula_seq: RTL and testbench
==========================

Name: ula_seq

Overview:
- Multi-cycle ALU (ULA) that sits directly downstream of the ALU control decoder; consumes its 4-bit ALUControl code and the datapath operands.
- Logic, arithmetic and compare ops complete in one cycle.
- Shifts are executed serially, one bit position per cycle, to save area.
- A start/busy/done handshake lets the multicycle control FSM stall until the result is valid.

Parameters:
- WIDTH, 32, operand/result width in bits.
- SHW, 5, shift-amount width; must equal log2(WIDTH).

Ports:
- clk  input  1  rising-edge clock
- reset  input  1  synchronous, active-high reset
- start  input  1  request; sampled only in IDLE
- ALUControl  input  4  operation code from the ALU control decoder
- A  input  WIDTH  operand rs
- B  input  WIDTH  operand rt
- shamt  input  SHW  instruction shift amount (SLL/SRL/SRA)
- result  output  WIDTH  registered result, held until the next completion
- zero  output  1  registered zero/branch flag
- overflow  output  1  registered signed overflow (ADD/SUB only)
- illegal  output  1  registered: last op code was undefined
- busy  output  1  high while an operation is in progress
- done  output  1  one-cycle pulse when result/flags are updated

Behaviour:
- Interface: one clock (clk); reset is synchronous and active-high.
- Reset: state=IDLE; result=0, zero=0, overflow=0, illegal=0, busy=0, done=0. Reset mid-operation aborts it; no done is produced.
- Operands are latched on the accepting edge. Input changes afterwards do not affect the op in flight.
- Code map (ALUControl):
  - 0000 AND; 0001 OR; 0010 ADD; 0110 SUB; 1011 XOR; 1100 NOR.
  - 0111 SLT (signed A<B -> 1 else 0); 1111 SLTU (unsigned).
  - 1000 BNE: result=A-B, zero=1 when A!=B.
  - 1001 SLL, 1010 SRL, 1101 SRA: shift B by shamt.
  - 0011 SLLV, 0100 SRLV, 0101 SRAV: shift B by A[SHW-1:0].
  - 1110 is undefined: result=0, zero=0, overflow=0, illegal=1.
- Flags:
  - zero = (result==0) for all defined codes except BNE.
  - overflow set only for ADD/SUB, on signed overflow; 0 for every other code.
  - illegal=0 for all defined codes.
- FSM states: IDLE, SHIFT, FIN.
  - IDLE & start & non-shift code: compute combinationally, register into internal hold, go FIN.
  - IDLE & start & shift code with amount k=0: result=B, go FIN.
  - IDLE & start & shift code with k>0: load shift reg=B, cnt=k, go SHIFT.
  - SHIFT: each cycle shift one bit (left fill 0; right logical fill 0; arithmetic fill MSB) and decrement cnt. Go FIN when cnt becomes 0.
  - FIN: drive result/zero/overflow/illegal outputs, done=1 for exactly this cycle, return to IDLE.
- Latency: done is asserted in the cycle after the accept edge for non-shift ops and k=0. For shift amount k>0, done is asserted k+1 cycles after the accept edge.
- busy = (state != IDLE), i.e. high in both SHIFT and FIN. start while busy is ignored, not queued.
- start in the FIN cycle is ignored. A new start is accepted on the IDLE cycle right after done, giving back-to-back throughput of one op every 2 cycles for non-shifts.
- Outputs change only in the done cycle; they are stable at all other times.
- Maximum shift: k=WIDTH-1 gives a latency of WIDTH cycles. Amounts are taken modulo 2^SHW by construction.

Test Plan:
- Reset mid-op: SRL with B=0xFFFF0000, shamt=16; assert reset at cycle 5 -> busy=0 next cycle, no done, all outputs 0.
- Single-cycle ops and flags:
  - ADD A=0x7FFFFFFF, B=1 -> done 1 cycle later; result=0x80000000, overflow=1, zero=0.
  - SUB A=5, B=5 -> result=0, zero=1, overflow=0.
- Compares:
  - SLT A=0xFFFFFFFF, B=1 -> result=1.
  - SLTU with the same operands -> result=0.
  - BNE A=3, B=4 -> zero=1.
  - BNE A=4, B=4 -> zero=0.
- Serial shifts:
  - SRA B=0x80000000, shamt=31 -> done exactly 32 cycles after accept; result=0xFFFFFFFF; busy high throughout.
  - SLLV A=4, B=1 -> result=0x10 after 5 cycles.
  - SLL shamt=0, B=0x1234 -> result=0x1234 after 1 cycle.
- Handshake: pulse start with new operands while busy during a shift -> ignored, first result unaffected. start held high continuously -> ops accepted every 2 cycles for non-shifts.
- Undefined code 1110 with A=B=0xFFFFFFFF -> result=0, illegal=1, overflow=0, zero=0. A following AND -> illegal returns to 0.

Source files
------------

// File: rtl/ula_seq_if.sv
// Handshake and operand bundle between the multicycle control FSM (master)
// and the sequential ALU (slave).
interface ula_seq_if #(
    parameter int WIDTH = 32,
    parameter int SHW   = 5
);
    logic             start;
    logic [3:0]       ALUControl;
    logic [WIDTH-1:0] A;
    logic [WIDTH-1:0] B;
    logic [SHW-1:0]   shamt;
    logic [WIDTH-1:0] result;
    logic             zero;
    logic             overflow;
    logic             illegal;
    logic             busy;
    logic             done;

    modport master (
        output start, ALUControl, A, B, shamt,
        input  result, zero, overflow, illegal, busy, done
    );

    modport slave (
        input  start, ALUControl, A, B, shamt,
        output result, zero, overflow, illegal, busy, done
    );
endinterface

// File: rtl/ula_seq.sv
// Multi-cycle ALU: logic/arith/compare ops finish in one cycle, shifts are
// performed serially one bit per cycle. start/busy/done handshake.
module ula_seq #(
    parameter int WIDTH = 32,
    parameter int SHW   = 5
) (
    input logic     clk,
    input logic     reset,
    ula_seq_if.slave bus
);
    typedef enum logic [1:0] {IDLE, SHIFT, FIN} state_t;

    state_t           state_q;
    logic [WIDTH-1:0] result_q;
    logic             zero_q, overflow_q, illegal_q, done_q;
    logic [WIDTH-1:0] sh_q;
    logic [SHW-1:0]   cnt_q;
    logic             left_q, arith_q;

    logic             is_shift, is_var, dec_left, dec_arith;
    logic [SHW-1:0]   amt;
    logic [WIDTH-1:0] sum, diff, alu_res;
    logic             alu_ovf, alu_ill, alu_zero;
    logic [WIDTH-1:0] sh_d;

    always_comb begin
        is_shift  = 1'b0;
        is_var    = 1'b0;
        dec_left  = 1'b0;
        dec_arith = 1'b0;
        case (bus.ALUControl)
            4'b1001: begin is_shift = 1'b1; dec_left = 1'b1; end
            4'b1010: begin is_shift = 1'b1; end
            4'b1101: begin is_shift = 1'b1; dec_arith = 1'b1; end
            4'b0011: begin is_shift = 1'b1; is_var = 1'b1; dec_left = 1'b1; end
            4'b0100: begin is_shift = 1'b1; is_var = 1'b1; end
            4'b0101: begin is_shift = 1'b1; is_var = 1'b1; dec_arith = 1'b1; end
            default: ;
        endcase
        amt = is_var ? bus.A[SHW-1:0] : bus.shamt;
    end

    assign sum  = bus.A + bus.B;
    assign diff = bus.A - bus.B;

    always_comb begin
        alu_res = '0;
        alu_ovf = 1'b0;
        alu_ill = 1'b0;
        case (bus.ALUControl)
            4'b0000: alu_res = bus.A & bus.B;
            4'b0001: alu_res = bus.A | bus.B;
            4'b0010: begin
                alu_res = sum;
                alu_ovf = (bus.A[WIDTH-1] == bus.B[WIDTH-1]) && (sum[WIDTH-1] != bus.A[WIDTH-1]);
            end
            4'b0110: begin
                alu_res = diff;
                alu_ovf = (bus.A[WIDTH-1] != bus.B[WIDTH-1]) && (diff[WIDTH-1] != bus.A[WIDTH-1]);
            end
            4'b1011: alu_res = bus.A ^ bus.B;
            4'b1100: alu_res = ~(bus.A | bus.B);
            4'b0111: alu_res = {{(WIDTH-1){1'b0}}, $signed(bus.A) < $signed(bus.B)};
            4'b1111: alu_res = {{(WIDTH-1){1'b0}}, bus.A < bus.B};
            4'b1000: alu_res = diff;
            4'b1110: alu_ill = 1'b1;
            default: ;
        endcase
        // BNE reuses the subtractor but reports inequality on the zero flag
        if (bus.ALUControl == 4'b1000)
            alu_zero = (bus.A != bus.B);
        else
            alu_zero = !alu_ill && (alu_res == '0);
    end

    for (genvar gi = 0; gi < WIDTH; gi++) begin : g_shift_bit
        if (gi == 0) begin : g_lsb
            assign sh_d[gi] = left_q ? 1'b0 : sh_q[gi+1];
        end else if (gi == WIDTH-1) begin : g_msb
            assign sh_d[gi] = left_q ? sh_q[gi-1] : (arith_q & sh_q[gi]);
        end else begin : g_mid
            assign sh_d[gi] = left_q ? sh_q[gi-1] : sh_q[gi+1];
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q    <= IDLE;
            result_q   <= '0;
            zero_q     <= 1'b0;
            overflow_q <= 1'b0;
            illegal_q  <= 1'b0;
            done_q     <= 1'b0;
            sh_q       <= '0;
            cnt_q      <= '0;
            left_q     <= 1'b0;
            arith_q    <= 1'b0;
        end else begin
            done_q <= 1'b0;
            case (state_q)
                IDLE: if (bus.start) begin
                    if (!is_shift) begin
                        result_q   <= alu_res;
                        zero_q     <= alu_zero;
                        overflow_q <= alu_ovf;
                        illegal_q  <= alu_ill;
                        done_q     <= 1'b1;
                        state_q    <= FIN;
                    end else if (amt == '0) begin
                        result_q   <= bus.B;
                        zero_q     <= (bus.B == '0);
                        overflow_q <= 1'b0;
                        illegal_q  <= 1'b0;
                        done_q     <= 1'b1;
                        state_q    <= FIN;
                    end else begin
                        sh_q    <= bus.B;
                        cnt_q   <= amt;
                        left_q  <= dec_left;
                        arith_q <= dec_arith;
                        state_q <= SHIFT;
                    end
                end
                SHIFT: begin
                    sh_q  <= sh_d;
                    cnt_q <= cnt_q - SHW'(1);
                    if (cnt_q == SHW'(1)) begin
                        result_q   <= sh_d;
                        zero_q     <= (sh_d == '0);
                        overflow_q <= 1'b0;
                        illegal_q  <= 1'b0;
                        done_q     <= 1'b1;
                        state_q    <= FIN;
                    end
                end
                FIN:     state_q <= IDLE;
                default: state_q <= IDLE;
            endcase
        end
    end

    assign bus.result   = result_q;
    assign bus.zero     = zero_q;
    assign bus.overflow = overflow_q;
    assign bus.illegal  = illegal_q;
    assign bus.done     = done_q;
    assign bus.busy     = (state_q != IDLE);
endmodule

// File: tb/tb_ula_seq.sv
// Randomized bench for ula_seq against an arithmetic reference model,
// plus directed cases for flags, latency, handshake and reset abort.
module tb_ula_seq;
    logic clk = 1'b0;
    logic reset;
    always #5 clk = ~clk;

    ula_seq_if #(.WIDTH(32), .SHW(5)) bus ();
    ula_seq #(.WIDTH(32), .SHW(5)) dut (.clk(clk), .reset(reset), .bus(bus));

    int checks   = 0;
    int failures = 0;

    typedef struct packed {
        logic [31:0] res;
        logic        z;
        logic        ov;
        logic        ill;
        logic [7:0]  lat;
    } exp_t;

    logic [31:0] prev_res;
    logic [2:0]  prev_flags;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=%h exp=%h", tag, got, exp);
        end
    endtask

    function automatic exp_t model(input logic [3:0] c, input logic [31:0] a, input logic [31:0] b,
                                   input logic [4:0] sh);
        exp_t   e;
        int     sa, sb, k;
        longint wide;
        sa = a; sb = b; k = -1;
        e = '0;
        case (c)
            4'b0000: e.res = a & b;
            4'b0001: e.res = a | b;
            4'b0010: begin
                e.res = a + b;
                wide  = longint'(sa) + longint'(sb);
                e.ov  = (wide != longint'(int'(e.res)));
            end
            4'b0110: begin
                e.res = a - b;
                wide  = longint'(sa) - longint'(sb);
                e.ov  = (wide != longint'(int'(e.res)));
            end
            4'b1011: e.res = a ^ b;
            4'b1100: e.res = ~(a | b);
            4'b0111: e.res = (sa < sb) ? 32'd1 : 32'd0;
            4'b1111: e.res = (a < b) ? 32'd1 : 32'd0;
            4'b1000: e.res = a - b;
            4'b1001: begin k = sh;     e.res = b << k; end
            4'b1010: begin k = sh;     e.res = b >> k; end
            4'b1101: begin k = sh;     e.res = sb >>> k; end
            4'b0011: begin k = a[4:0]; e.res = b << k; end
            4'b0100: begin k = a[4:0]; e.res = b >> k; end
            4'b0101: begin k = a[4:0]; e.res = sb >>> k; end
            default: e.ill = 1'b1;
        endcase
        e.z   = (c == 4'b1000) ? (a != b) : (!e.ill && e.res == 32'd0);
        e.lat = (k > 0) ? 8'(k + 1) : 8'd1;
        return e;
    endfunction

    task automatic run_op(input logic [3:0] c, input logic [31:0] a, input logic [31:0] b,
                          input logic [4:0] sh, input bit poke);
        exp_t e;
        int   cyc;
        e = model(c, a, b, sh);
        @(negedge clk);
        bus.ALUControl = c; bus.A = a; bus.B = b; bus.shamt = sh; bus.start = 1'b1;
        @(negedge clk);
        bus.start = 1'b0;
        bus.A = $urandom; bus.B = $urandom; bus.shamt = 5'($urandom); bus.ALUControl = 4'($urandom);
        cyc = 1;
        while (!bus.done && cyc < 80) begin
            check("busy_wait", {31'd0, bus.busy}, 32'd1);
            check("hold", {bus.result ^ prev_res, 26'd0, bus.zero, bus.overflow, bus.illegal, 3'd0},
                  {32'd0 ^ 32'd0, 26'd0, prev_flags, 3'd0});
            bus.start = (poke && cyc == 2);
            @(negedge clk);
            bus.start = 1'b0;
            cyc++;
        end
        if (!bus.done) begin
            check("timeout", 32'd0, 32'd1);
        end else begin
            check("latency", cyc, {24'd0, e.lat});
            check("result", bus.result, e.res);
            check("flags", {29'd0, bus.zero, bus.overflow, bus.illegal}, {29'd0, e.z, e.ov, e.ill});
            check("busy_fin", {31'd0, bus.busy}, 32'd1);
        end
        prev_res   = e.res;
        prev_flags = {e.z, e.ov, e.ill};
        $display("op c=%b a=%h b=%h sh=%0d poke=%0d res=%h z=%b ov=%b ill=%b lat=%0d",
                 c, a, b, sh, poke, bus.result, bus.zero, bus.overflow, bus.illegal, cyc);
        @(negedge clk);
        check("done_pulse", {31'd0, bus.done}, 32'd0);
        check("idle", {31'd0, bus.busy}, 32'd0);
    endtask

    initial begin
        logic [3:0]  rc;
        logic        seen_done;
        exp_t        e;
        reset = 1'b1;
        bus.start = 1'b0; bus.ALUControl = 4'd0; bus.A = '0; bus.B = '0; bus.shamt = '0;
        prev_res = '0; prev_flags = '0;
        repeat (3) @(negedge clk);
        check("rst_result", bus.result, 32'd0);
        check("rst_ctl", {27'd0, bus.zero, bus.overflow, bus.illegal, bus.busy, bus.done}, 32'd0);
        reset = 1'b0;

        run_op(4'b0010, 32'h7FFFFFFF, 32'd1, 5'd0, 0);
        run_op(4'b0110, 32'd5, 32'd5, 5'd0, 0);
        run_op(4'b0111, 32'hFFFFFFFF, 32'd1, 5'd0, 0);
        run_op(4'b1111, 32'hFFFFFFFF, 32'd1, 5'd0, 0);
        run_op(4'b1000, 32'd3, 32'd4, 5'd0, 0);
        run_op(4'b1000, 32'd4, 32'd4, 5'd0, 0);
        run_op(4'b1101, 32'd0, 32'h80000000, 5'd31, 1);
        run_op(4'b0011, 32'd4, 32'd1, 5'd0, 1);
        run_op(4'b1001, 32'd0, 32'h1234, 5'd0, 0);
        run_op(4'b1110, 32'hFFFFFFFF, 32'hFFFFFFFF, 5'd0, 0);
        run_op(4'b0000, 32'hF0F0F0F0, 32'hFF00FF00, 5'd0, 0);
        run_op(4'b1010, 32'd0, 32'hFFFF0000, 5'd16, 1);

        // Reset during a serial shift aborts it and clears every output
        @(negedge clk);
        bus.ALUControl = 4'b1010; bus.B = 32'hFFFF0000; bus.shamt = 5'd16; bus.start = 1'b1;
        @(negedge clk);
        bus.start = 1'b0;
        repeat (4) @(negedge clk);
        reset = 1'b1;
        @(negedge clk);
        reset = 1'b0;
        check("abort_result", bus.result, 32'd0);
        check("abort_ctl", {27'd0, bus.zero, bus.overflow, bus.illegal, bus.busy, bus.done}, 32'd0);
        seen_done = 1'b0;
        repeat (20) begin
            @(negedge clk);
            seen_done |= bus.done;
        end
        check("abort_no_done", {31'd0, seen_done}, 32'd0);
        $display("op reset-abort SRL b=ffff0000 sh=16");
        prev_res = '0; prev_flags = '0;

        // start held high: one non-shift op accepted every second cycle
        e = model(4'b0001, 32'h00FF0000, 32'h0000ABCD, 5'd0);
        @(negedge clk);
        bus.ALUControl = 4'b0001; bus.A = 32'h00FF0000; bus.B = 32'h0000ABCD; bus.start = 1'b1;
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            check("held_done", {31'd0, bus.done}, (i % 2 == 0) ? 32'd1 : 32'd0);
            if (bus.done) check("held_result", bus.result, e.res);
        end
        bus.start = 1'b0;
        @(negedge clk);
        $display("op held-start OR res=%h", bus.result);
        prev_res = e.res; prev_flags = {e.z, e.ov, e.ill};
        @(negedge clk);

        for (int n = 0; n < 200; n++) begin
            rc = 4'($urandom);
            case ($urandom_range(0, 3))
                0:       run_op(rc, $urandom, $urandom, 5'($urandom), 1'($urandom));
                1:       run_op(rc, 32'($urandom_range(0, 3)), 32'($urandom_range(0, 3)), 5'($urandom_range(0, 2)), 0);
                2:       run_op(rc, {1'b0, 31'($urandom)}, {1'b0, 31'($urandom)}, 5'd31, 1);
                default: run_op(rc, {1'b1, 31'($urandom)}, {1'b1, 31'($urandom)}, 5'($urandom), 0);
            endcase
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
